// File: rtl/ins_mem_loader_if.sv
// Loader-side bundle: inbound instruction stream plus the instruction-memory write port.
interface ins_mem_loader_if #(
  parameter int IR_width = 12,
  parameter int Im_width = 8
);
  logic [IR_width-1:0] in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  logic [Im_width-1:0] im_address;
  logic [IR_width-1:0] im_data;
  logic                im_wren;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, im_address, im_data, im_wren
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, im_address, im_data, im_wren
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Boot-time instruction-memory writer: streams words to address 0.., verifies a trailing
// checksum, holds the CPU while loading and pulses start on success.
module ins_mem_loader #(
  parameter int IR_width = 12,
  parameter int Im_width = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  ins_mem_loader_if.slave     bus,
  output logic                cpu_hold,
  output logic                start,
  output logic                done,
  output logic                error,
  output logic [Im_width:0]   word_count
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, START, DONE, ERR} state_t;

  state_t              state, state_nxt;
  logic [Im_width-1:0] addr;
  logic [IR_width-1:0] sum;
  logic [IR_width-1:0] csum;
  logic [Im_width-1:0] wr_addr;
  logic [IR_width-1:0] wr_data;
  logic                wr_en;
  logic                accept;
  logic                write_word;
  logic                clear;
  logic                full;

  // Memory already holds 2^Im_width words once the count's top bit is set.
  assign full = word_count[Im_width];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    cpu_hold     = 1'b0;
    start        = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    accept       = 1'b0;
    write_word   = 1'b0;
    clear        = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        done  = (state == DONE);
        error = (state == ERR);
        if (load_req) begin
          state_nxt = LOAD;
          clear     = 1'b1;
        end
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        cpu_hold     = 1'b1;
        accept       = bus.in_valid;
        if (accept) begin
          if (bus.in_last)  state_nxt = (word_count == '0) ? ERR : CHECK;
          else if (full)    state_nxt = ERR;
          else              write_word = 1'b1;
        end
      end
      CHECK: begin
        cpu_hold  = 1'b1;
        state_nxt = (csum == sum) ? START : ERR;
      end
      START: begin
        start     = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The internal address rolls over only after the final permitted write; full blocks any use of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      sum        <= '0;
      csum       <= '0;
      word_count <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= write_word;
      if (clear) begin
        addr       <= '0;
        sum        <= '0;
        word_count <= '0;
      end else if (write_word) begin
        wr_addr    <= addr;
        wr_data    <= bus.in_data;
        addr       <= addr + 1'b1;
        word_count <= word_count + 1'b1;
        sum        <= sum + bus.in_data;
      end
      if (accept && bus.in_last) csum <= bus.in_data;
    end
  end

  assign bus.im_address = wr_addr;
  assign bus.im_data    = wr_data;
  assign bus.im_wren    = wr_en;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Randomised scoreboard bench for ins_mem_loader at a 4-word memory so overflow is reachable.
module tb_ins_mem_loader;
  localparam int IRW = 12;
  localparam int IMW = 2;
  localparam int CAP = 1 << IMW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load_req = 1'b0;
  logic           cpu_hold, start, done, error;
  logic [IMW:0]   word_count;

  ins_mem_loader_if #(.IR_width(IRW), .Im_width(IMW)) bus ();

  ins_mem_loader #(.IR_width(IRW), .Im_width(IMW)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .bus(bus),
    .cpu_hold(cpu_hold), .start(start), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t          wr_q[$];
  int unsigned  start_q[$];
  logic [IRW:0] stim[$];
  int unsigned  cyc = 0;
  int           total = 0;
  int           bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  task automatic add(input logic l, input int unsigned d);
    stim.push_back({l, d[IRW-1:0]});
  endtask

  // Monitor: 'now' is the cycle that began at the most recent rising edge.
  wr_t         wr_e;
  int unsigned st_e;
  int unsigned now;
  always @(negedge clk) begin
    if (!reset) begin
      now = cyc + 1;
      while (wr_q.size() > 0 && wr_q[0].at < now) begin
        wr_e = wr_q.pop_front();
        total++; bad++;
        $display("FAIL missing_write: addr 0x%0h data 0x%0h never written, expected in cycle %0d",
                 wr_e.addr, wr_e.data, wr_e.at);
      end
      if (bus.im_wren) begin
        if (wr_q.size() == 0 || wr_q[0].at != now) begin
          total++; bad++;
          $display("FAIL unexpected_write: got wren=1 addr 0x%0h data 0x%0h, expected wren=0 (cycle %0d)",
                   bus.im_address, bus.im_data, now);
        end else begin
          wr_e = wr_q.pop_front();
          chk("write_addr", int'(bus.im_address), wr_e.addr);
          chk("write_data", int'(bus.im_data), wr_e.data);
        end
      end
      while (start_q.size() > 0 && start_q[0] < now) begin
        st_e = start_q.pop_front();
        total++; bad++;
        $display("FAIL missing_start: got start=0 expected start=1 in cycle %0d", st_e);
      end
      if (start) begin
        if (start_q.size() == 0 || start_q[0] != now) begin
          total++; bad++;
          $display("FAIL unexpected_start: got start=1 expected 0 (cycle %0d)", now);
        end else begin
          st_e = start_q.pop_front();
          chk("start_cycle", now, st_e);
        end
      end
    end
  end

  // bp: 0 none, 1 gap before every word, 2 random gaps. noise: random load_req while loading.
  task automatic run_load(input int bp, input bit noise);
    int unsigned cnt = 0;
    int unsigned sum = 0;
    int unsigned d;
    int unsigned k;
    bit          exp_done = 1'b0;
    bit          exp_err = 1'b0;
    bit          finished = 1'b0;
    logic [IRW:0] w;
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    for (int i = 0; i < stim.size() && !finished; i++) begin
      w = stim[i];
      d = int'(w[IRW-1:0]);
      if (bp == 1 || (bp == 2 && $urandom_range(1, 0) == 1)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = IRW'($urandom);
        load_req     = noise && ($urandom_range(1, 0) == 1);
        @(negedge clk);
        chk("hold_in_gap", cpu_hold, 1);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w[IRW-1:0];
      bus.in_last  = w[IRW];
      load_req     = noise && ($urandom_range(1, 0) == 1);
      @(negedge clk);
      chk("in_ready", bus.in_ready, 1);
      chk("hold_in_load", cpu_hold, 1);
      k = cyc + 1;
      if (w[IRW]) begin
        finished = 1'b1;
        if (cnt != 0 && d == sum) begin
          exp_done = 1'b1;
          start_q.push_back(k + 2);
        end else begin
          exp_err = 1'b1;
        end
      end else if (cnt == CAP) begin
        finished = 1'b1;
        exp_err  = 1'b1;
      end else begin
        wr_q.push_back('{at: k + 1, addr: cnt, data: d});
        cnt++;
        sum = (sum + d) % (1 << IRW);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    load_req     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("done", done, exp_done);
    chk("error", error, exp_err);
    chk("word_count", int'(word_count), cnt);
    chk("hold_after", cpu_hold, 0);
    chk("ready_after", bus.in_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int unsigned len, s, dr, rk;
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.in_ready, bus.im_wren, bus.im_address, bus.im_data,
                          cpu_hold, start, done, error, word_count}, 0);
    reset = 1'b0;

    stim.delete(); add(0, 'h123); add(0, 'h456); add(0, 'h789); add(1, 'hD02);
    run_load(0, 1'b0);
    stim.delete(); add(0, 'h123); add(0, 'h456); add(0, 'h789); add(1, 'hD03);
    run_load(0, 1'b0);
    stim.delete(); add(0, 'hFFF); add(0, 'h002); add(1, 'h001);
    run_load(1, 1'b0);
    stim.delete(); add(0, 'h111); add(0, 'h222); add(0, 'h333); add(0, 'h444); add(0, 'h555); add(1, 'h000);
    run_load(0, 1'b0);
    stim.delete(); add(1, 'h000);
    run_load(0, 1'b1);
    stim.delete(); add(0, 'h123); add(0, 'h456); add(0, 'h789); add(1, 'hD02);
    run_load(2, 1'b1);

    // Reset in the cycle the second write is on the bus; that write must be dropped.
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IRW'(32'h0B0 + i);
      bus.in_last  = 1'b0;
      @(negedge clk);
      chk("in_ready_pre_reset", bus.in_ready, 1);
      rk = cyc + 1;
      wr_q.push_back('{at: rk + 1, addr: unsigned'(i), data: 32'h0B0 + unsigned'(i)});
      @(posedge clk); #1;
    end
    bus.in_data = 'h0C0;
    #2;
    wr_q.delete();
    reset = 1'b1;
    #1;
    chk("reset_mid_load", {bus.in_ready, bus.im_wren, bus.im_address, bus.im_data,
                           cpu_hold, start, done, error, word_count}, 0);
    bus.in_valid = 1'b0;
    load_req     = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("req_in_reset_ignored", {bus.in_ready, cpu_hold}, 0);
    stim.delete(); add(0, 'h00A); add(1, 'h00A);
    run_load(0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(CAP + 1, 0);
      s = 0;
      stim.delete();
      for (int j = 0; j < int'(len); j++) begin
        dr = $urandom_range((1 << IRW) - 1, 0);
        s  = (s + dr) % (1 << IRW);
        add(0, dr);
      end
      add(1, ($urandom_range(3, 0) == 0) ? $urandom_range((1 << IRW) - 1, 0) : s);
      run_load(2, $urandom_range(1, 0) == 1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("leftover_writes", wr_q.size(), 0);
    chk("leftover_starts", start_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
